// File: rtl/regfile_sb.sv
// rtl/regfile_sb.sv - register file with pending-writer scoreboard
//
// Purpose:
//   Register file with 2**ADDR_W entries and two read ports. Entry r0 is
//   hardwired to zero. Alongside the data it keeps a scoreboard: one pending
//   bit per register, set when decode issues a writer and cleared when the
//   write-back stage delivers the result. A registered count of pending bits
//   is kept as well.
//
// Optional feature:
//   REGFILE_BYPASS_EN - when defined, a read that hits the register being
//   written back this cycle returns wdata directly, and its busy flag is
//   suppressed unless a new writer to that register issues in the same cycle.
//
// Ports:
//   clk                 clock, all state updates on posedge
//   rst                 asynchronous active-low reset
//   we, waddr, wdata    write-back port (also clears pending[waddr])
//   re1/re2             read enables
//   raddr1/raddr2       read addresses
//   rdata1/rdata2       combinational read data
//   issue_we/issue_addr decode issue; sets pending[issue_addr]
//   busy1/busy2         source operand has an outstanding writer
//   busy_cnt            number of registers currently pending
module regfile_sb #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re1,
  input  logic              re2,
  input  logic [ADDR_W-1:0] raddr1,
  input  logic [ADDR_W-1:0] raddr2,
  output logic [DATA_W-1:0] rdata1,
  output logic [DATA_W-1:0] rdata2,
  input  logic              issue_we,
  input  logic [ADDR_W-1:0] issue_addr,
  output logic              busy1,
  output logic              busy2,
  output logic [ADDR_W:0]   busy_cnt
);

  localparam int NREG = 1 << ADDR_W;

  logic [DATA_W-1:0] mem_q [NREG];
  logic [DATA_W-1:0] mem_d [NREG];
  logic [NREG-1:0]   pending_q;
  logic [NREG-1:0]   pending_d;
  logic [ADDR_W:0]   busy_cnt_q;
  logic [ADDR_W:0]   busy_cnt_d;

  logic wr_en;
  logic set_en;
  logic set_new;
  logic clr_eff;

  assign wr_en  = we && (waddr != '0);
  assign set_en = issue_we && (issue_addr != '0);

  // A set counts only if the bit was clear. A clear counts only if the bit
  // was set and is not simultaneously re-set by a newer writer.
  assign set_new = set_en && !pending_q[issue_addr];
  assign clr_eff = wr_en && pending_q[waddr] &&
                   !(set_en && (issue_addr == waddr));

  always_comb begin
    mem_d = mem_q;
    if (wr_en) begin
      mem_d[waddr] = wdata;
    end
  end

  // Clear first, then set, so a same-cycle set/clear of one address leaves
  // the bit set.
  always_comb begin
    pending_d = pending_q;
    if (wr_en) begin
      pending_d[waddr] = 1'b0;
    end
    if (set_en) begin
      pending_d[issue_addr] = 1'b1;
    end
    pending_d[0] = 1'b0;
  end

  always_comb begin
    busy_cnt_d = busy_cnt_q;
    if (set_new && !clr_eff) begin
      busy_cnt_d = busy_cnt_q + 1'b1;
    end else if (clr_eff && !set_new) begin
      busy_cnt_d = busy_cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NREG; i++) begin
        mem_q[i] <= '0;
      end
      pending_q  <= '0;
      busy_cnt_q <= '0;
    end else begin
      for (int i = 0; i < NREG; i++) begin
        mem_q[i] <= mem_d[i];
      end
      pending_q  <= pending_d;
      busy_cnt_q <= busy_cnt_d;
    end
  end

  assign busy_cnt = busy_cnt_q;

  // Read port 1
  always_comb begin
    rdata1 = '0;
    busy1  = 1'b0;
    if (re1 && (raddr1 != '0)) begin
      rdata1 = mem_q[raddr1];
      busy1  = pending_q[raddr1];
`ifdef REGFILE_BYPASS_EN
      if (wr_en && (waddr == raddr1)) begin
        rdata1 = wdata;
        // The forwarded value satisfies the read unless a newer writer to
        // the same register is issuing right now.
        if (!(issue_we && (issue_addr == raddr1))) begin
          busy1 = 1'b0;
        end
      end
`endif
    end
  end

  // Read port 2
  always_comb begin
    rdata2 = '0;
    busy2  = 1'b0;
    if (re2 && (raddr2 != '0)) begin
      rdata2 = mem_q[raddr2];
      busy2  = pending_q[raddr2];
`ifdef REGFILE_BYPASS_EN
      if (wr_en && (waddr == raddr2)) begin
        rdata2 = wdata;
        if (!(issue_we && (issue_addr == raddr2))) begin
          busy2 = 1'b0;
        end
      end
`endif
    end
  end

endmodule

// File: tb/tb_regfile_sb.sv
// tb/tb_regfile_sb.sv - directed self-checking bench for regfile_sb
module tb_regfile_sb;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;

  logic              clk;
  logic              rst;
  logic              we;
  logic [ADDR_W-1:0] waddr;
  logic [DATA_W-1:0] wdata;
  logic              re1;
  logic              re2;
  logic [ADDR_W-1:0] raddr1;
  logic [ADDR_W-1:0] raddr2;
  logic [DATA_W-1:0] rdata1;
  logic [DATA_W-1:0] rdata2;
  logic              issue_we;
  logic [ADDR_W-1:0] issue_addr;
  logic              busy1;
  logic              busy2;
  logic [ADDR_W:0]   busy_cnt;

  int n_tests;
  int n_fail;

  regfile_sb #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .we         (we),
    .waddr      (waddr),
    .wdata      (wdata),
    .re1        (re1),
    .re2        (re2),
    .raddr1     (raddr1),
    .raddr2     (raddr2),
    .rdata1     (rdata1),
    .rdata2     (rdata2),
    .issue_we   (issue_we),
    .issue_addr (issue_addr),
    .busy1      (busy1),
    .busy2      (busy2),
    .busy_cnt   (busy_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1 time unit
  // after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    we = 1'b0;
    issue_we = 1'b0;
  endtask

  logic [31:0] exp_byp;

  initial begin
    n_tests = 0;
    n_fail = 0;
    rst = 1'b0;
    we = 1'b0; waddr = '0; wdata = '0;
    re1 = 1'b0; re2 = 1'b0; raddr1 = '0; raddr2 = '0;
    issue_we = 1'b0; issue_addr = '0;
    repeat (2) tick();
    chk("reset_cnt", 32'(busy_cnt), 32'd0);
    rst = 1'b1;
    tick();

    // Write r5, read next cycle
    we = 1'b1; waddr = 5'd5; wdata = 32'hDEADBEEF;
    tick();
    idle();
    re1 = 1'b1; raddr1 = 5'd5;
    #1;
    chk("rd_r5", rdata1, 32'hDEADBEEF);
    re2 = 1'b1; raddr2 = 5'd5;
    #1;
    chk("rd_same_addr", rdata2, 32'hDEADBEEF);
    re1 = 1'b0;
    #1;
    chk("rd_disabled", rdata1, 32'd0);

    // Write to r0 is discarded
    we = 1'b1; waddr = 5'd0; wdata = 32'h1234;
    tick();
    idle();
    re1 = 1'b1; raddr1 = 5'd0;
    #1;
    chk("rd_r0", rdata1, 32'd0);

    // Same-cycle write/read of r7
    we = 1'b1; waddr = 5'd7; wdata = 32'hA5A5A5A5;
    re2 = 1'b1; raddr2 = 5'd7;
    #1;
`ifdef REGFILE_BYPASS_EN
    exp_byp = 32'hA5A5A5A5;
`else
    exp_byp = 32'd0;
`endif
    chk("bypass_r7", rdata2, exp_byp);
    tick();
    idle();
    #1;
    chk("rd_r7_after", rdata2, 32'hA5A5A5A5);

    // Scoreboard set/clear of r3
    issue_we = 1'b1; issue_addr = 5'd3;
    tick();
    idle();
    re1 = 1'b1; raddr1 = 5'd3;
    #1;
    chk("busy1_set", 32'(busy1), 32'd1);
    chk("cnt_set", 32'(busy_cnt), 32'd1);
    re1 = 1'b0;
    #1;
    chk("busy1_re0", 32'(busy1), 32'd0);
    re1 = 1'b1;
    we = 1'b1; waddr = 5'd3; wdata = 32'h33;
    tick();
    idle();
    #1;
    chk("busy1_clr", 32'(busy1), 32'd0);
    chk("cnt_clr", 32'(busy_cnt), 32'd0);

    // Collision on r9: newer writer keeps it pending
    issue_we = 1'b1; issue_addr = 5'd9;
    tick();
    idle();
    chk("cnt_r9", 32'(busy_cnt), 32'd1);
    issue_we = 1'b1; issue_addr = 5'd9;
    we = 1'b1; waddr = 5'd9; wdata = 32'h99;
    tick();
    idle();
    re2 = 1'b1; raddr2 = 5'd9;
    #1;
    chk("coll_cnt", 32'(busy_cnt), 32'd1);
    chk("coll_busy2", 32'(busy2), 32'd1);
    chk("coll_data", rdata2, 32'h99);
    we = 1'b1; waddr = 5'd9; wdata = 32'h9A;
    tick();
    idle();
    chk("coll_clr_cnt", 32'(busy_cnt), 32'd0);

    // Clear of a non-pending register does not change the count
    we = 1'b1; waddr = 5'd12; wdata = 32'h12;
    tick();
    idle();
    chk("clr_unpend", 32'(busy_cnt), 32'd0);

    // Saturation: issue r1..r31
    for (int a = 1; a < 32; a++) begin
      issue_we = 1'b1; issue_addr = ADDR_W'(a);
      tick();
    end
    idle();
    chk("sat_31", 32'(busy_cnt), 32'd31);
    issue_we = 1'b1; issue_addr = 5'd4;
    tick();
    idle();
    chk("sat_reissue", 32'(busy_cnt), 32'd31);
    we = 1'b1; waddr = 5'd0; wdata = 32'h5;
    tick();
    idle();
    chk("sat_clr_r0", 32'(busy_cnt), 32'd31);
    issue_we = 1'b1; issue_addr = 5'd0;
    tick();
    idle();
    chk("sat_issue_r0", 32'(busy_cnt), 32'd31);
    re1 = 1'b1; raddr1 = 5'd0;
    #1;
    chk("busy_r0", 32'(busy1), 32'd0);
    // Clear r4 while issuing the already-pending r6: net -1
    we = 1'b1; waddr = 5'd4; wdata = 32'h44;
    issue_we = 1'b1; issue_addr = 5'd6;
    tick();
    idle();
    chk("sat_clr_r4", 32'(busy_cnt), 32'd30);

    // Asynchronous reset mid-run with pending bits set
    #2;
    rst = 1'b0;
    #1;
    chk("rst_cnt", 32'(busy_cnt), 32'd0);
    re1 = 1'b1; re2 = 1'b1;
    for (int a = 0; a < 32; a++) begin
      raddr1 = ADDR_W'(a);
      raddr2 = ADDR_W'(31 - a);
      #1;
      chk($sformatf("rst_rd1_%0d", a), rdata1, 32'd0);
      chk($sformatf("rst_rd2_%0d", a), rdata2, 32'd0);
      chk($sformatf("rst_busy_%0d", a), {30'd0, busy1, busy2}, 32'd0);
    end
    tick();
    rst = 1'b1;
    tick();
    raddr1 = 5'd5;
    #1;
    chk("post_rst_r5", rdata1, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/regfile_sb.md
REGFILE_SB -- requirements
Module: regfile_sb

Interface
REQ-001 SHALL have parameter DATA_W, default 32, register data width.
REQ-002 SHALL have parameter ADDR_W, default 5, register address width (32 entries).
REQ-003 SHALL have port clk  input  1  single clock; all state updates on posedge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port we  input  1  write-back write enable; the write-back stage register drives it.
REQ-006 SHALL have port waddr  input  ADDR_W  write-back destination register.
REQ-007 SHALL have port wdata  input  DATA_W  write-back data.
REQ-008 SHALL have ports re1/re2  input  1  read-port enables.
REQ-009 SHALL have ports raddr1/raddr2  input  ADDR_W  read-port source registers.
REQ-010 SHALL have ports rdata1/rdata2  output  DATA_W  read data, combinational.
REQ-011 SHALL have port issue_we  input  1  decode issues an instruction that will write issue_addr.
REQ-012 SHALL have port issue_addr  input  ADDR_W  destination to mark pending.
REQ-013 SHALL have ports busy1/busy2  output  1  source operand has an outstanding writer.
REQ-014 SHALL have port busy_cnt  output  ADDR_W+1  number of registers currently pending.

Function
REQ-015 SHALL store entries r1..r31; r0 reads as 0 and writes to r0 are discarded.
REQ-016 SHALL write wdata into entry waddr at posedge clk when we=1 and waddr!=0.
REQ-017 SHALL drive rdataN=0 when reN=0 or raddrN=0; otherwise the entry value (subject to REQ-027).
REQ-018 SHALL keep a 32-bit pending vector; bit 0 is constant 0.
REQ-019 SHALL set pending[issue_addr] at posedge when issue_we=1 and issue_addr!=0.
REQ-020 SHALL clear pending[waddr] at posedge when we=1 and waddr!=0.
REQ-021 SHALL, on same-cycle set and clear of the same address, leave the bit set (newer writer wins).
REQ-022 SHALL ignore a clear of a non-pending bit and a set of an already-pending bit (no count change).
REQ-023 SHALL drive busyN = reN & pending[raddrN] (subject to REQ-028); busyN=0 when raddrN=0.
REQ-024 SHALL register busy_cnt: +1 per newly set bit, -1 per cleared bit not re-set in the same cycle; net change in {-1,0,+1}; range 0..31, no wrap.
REQ-025 SHALL keep both read ports fully independent; identical addresses give identical results.

Reset
REQ-026 SHALL, while rst=0, asynchronously force all entries, the pending vector and busy_cnt to 0; outputs then reflect zero state; a reset mid-operation discards all pending writes.

Configuration
REQ-027 With REGFILE_BYPASS_EN defined, rdataN SHALL return wdata when we=1, waddr=raddrN!=0 and reN=1; without it, rdataN returns the pre-write entry value, and the new value appears the cycle after the write.
REQ-028 With REGFILE_BYPASS_EN defined, busyN SHALL be 0 when the bypass of REQ-027 applies and issue_addr!=raddrN or issue_we=0; without it, busyN follows pending[] only.

Verification
REQ-029 Reset: rst=0 mid-run with pending bits set -> busy_cnt=0, rdata1/rdata2=0 for all addresses, busy1/busy2=0.
REQ-030 Write/read: we=1 waddr=5 wdata=0xDEADBEEF; next cycle re1=1 raddr1=5 -> rdata1=0xDEADBEEF; a write to r0 with 0x1234 -> a read of r0 returns 0.
REQ-031 Bypass: same-cycle we=1 waddr=7 wdata=0xA5A5A5A5, re2=1 raddr2=7 -> rdata2=0xA5A5A5A5 with the macro, the old value (0) without it.
REQ-032 Scoreboard: issue_we=1 issue_addr=3 -> next cycle busy1=1 (raddr1=3) and busy_cnt=1; we=1 waddr=3 -> next cycle busy1=0 and busy_cnt=0.
REQ-033 Collision: r9 pending, same cycle issue_we=1 issue_addr=9 and we=1 waddr=9 -> r9 still pending, busy_cnt unchanged; the data is written.
REQ-034 Saturation: issue r1..r31 -> busy_cnt=31; reissue r4 -> still 31; clear an unpending r0 -> no change.
